// File: rtl/axis_rng_range_if.sv
// AXI-Stream word channel (32-bit data, valid/ready) used on both sides of the
// range reducer.
interface axis_rng_range_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_rng_range.sv
// Unbiased bounded-range reducer: masks each raw word to the smallest 2^k-1
// covering range_max and drops candidates above the bound.
module axis_rng_range (
    input  logic                     clk,
    input  logic                     rst,
    axis_rng_range_if.slave          input_axis,
    axis_rng_range_if.master         output_axis,
    input  logic [31:0]              range_max,
    input  logic                     range_load,
    input  logic                     reject_clear,
    output logic                     busy,
    output logic [31:0]              reject_count
);

    localparam int DATA_W = 32;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   max_reg, max_next;
    logic [DATA_W-1:0]   mask_reg, mask_next;
    logic [DATA_W-1:0]   cand_p0;
    logic                accept_p0;
    logic                reject_p0;
    logic                in_ready;
    logic [DATA_W-1:0]   out_data_p1, out_data_next;
    logic                vld_p1, vld_next;
    logic [DATA_W-1:0]   reject_count_q, reject_count_next;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DATA_W-1:0] mask_grow(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], 1'b1};
    endfunction

    always_comb begin
        state_next    = state;
        max_next      = max_reg;
        mask_next     = mask_reg;
        out_data_next = out_data_p1;
        vld_next      = vld_p1 & ~output_axis.tready;
        in_ready      = 1'b0;
        accept_p0     = 1'b0;
        reject_p0     = 1'b0;
        cand_p0       = input_axis.tdata & mask_reg;

        case (state)
            RUN: begin
                in_ready  = ~vld_p1 | output_axis.tready;
                accept_p0 = in_ready & input_axis.tvalid;
                // A word accepted alongside range_load still uses the old bound.
                if (accept_p0) begin
                    if (cand_p0 <= max_reg) begin
                        out_data_next = cand_p0;
                        vld_next      = 1'b1;
                    end else begin
                        reject_p0 = 1'b1;
                    end
                end
                if (range_load) begin
                    max_next   = range_max;
                    mask_next  = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (range_load) begin
                    max_next  = range_max;
                    mask_next = '0;
                end else if (mask_reg >= max_reg) begin
                    state_next = RUN;
                end else begin
                    mask_next = mask_grow(mask_reg);
                end
            end
            default: state_next = RUN;
        endcase

        if (reject_clear)
            reject_count_next = '0;
        else if (reject_p0)
            reject_count_next = sat_inc(reject_count_q);
        else
            reject_count_next = reject_count_q;
    end

    // p1: registered output stage, bound/mask and FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            max_reg        <= '1;
            mask_reg       <= '1;
            out_data_p1    <= '0;
            vld_p1         <= 1'b0;
            reject_count_q <= '0;
        end else begin
            state          <= state_next;
            max_reg        <= max_next;
            mask_reg       <= mask_next;
            out_data_p1    <= out_data_next;
            vld_p1         <= vld_next;
            reject_count_q <= reject_count_next;
        end
    end

    assign input_axis.tready  = in_ready;
    assign output_axis.tdata  = out_data_p1;
    assign output_axis.tvalid = vld_p1;
    assign busy               = (state == CALC);
    assign reject_count       = reject_count_q;

endmodule

// File: tb/tb_axis_rng_range.sv
// Bench for axis_rng_range: vector table plus hand sequences, scoreboard-checked.
module tb_axis_rng_range;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] range_max;
    logic        range_load;
    logic        reject_clear;
    logic        busy;
    logic [31:0] reject_count;

    always #5 clk = ~clk;

    axis_rng_range_if in_if ();
    axis_rng_range_if out_if ();

    axis_rng_range dut (
        .clk          (clk),
        .rst          (rst),
        .input_axis   (in_if),
        .output_axis  (out_if),
        .range_max    (range_max),
        .range_load   (range_load),
        .reject_clear (reject_clear),
        .busy         (busy),
        .reject_count (reject_count)
    );

    typedef struct {
        logic [31:0] rmax;
        int          busy_cyc;
        logic [31:0] din;
        bit          pass;
        logic [31:0] dout;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_rej;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [31:0] sat_add1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Output monitor: every completed output handshake is checked against the queue.
    always @(negedge clk) begin
        if (!rst && out_if.tvalid && out_if.tready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got %h required no output", out_if.tdata);
            end else begin
                chk("out_data", out_if.tdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] w, input bit pass, input logic [31:0] e);
        int n = 0;
        in_if.tdata  = w;
        in_if.tvalid = 1'b1;
        @(negedge clk);
        while (!in_if.tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_if.tready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: tready %b required 1", in_if.tready);
        end else if (pass) begin
            exp_q.push_back(e);
        end else begin
            exp_rej = sat_add1(exp_rej);
        end
        @(posedge clk);
        #1;
        in_if.tvalid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] r);
        range_max  = r;
        range_load = 1'b1;
        @(posedge clk);
        #1;
        range_load = 1'b0;
    endtask

    task automatic wait_calc(input string name, input int exp_cycles);
        int n = 0;
        bit rdy_seen = 1'b0;
        @(negedge clk);
        while (busy && n < 100) begin
            if (in_if.tready) rdy_seen = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, n, exp_cycles);
        chk({name, "_tready_in_calc"}, {31'd0, rdy_seen}, 32'd0);
        chk({name, "_tready_after"}, {31'd0, in_if.tready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [31:0] r, input int b, input logic [31:0] d,
                                input bit p, input logic [31:0] o);
        vec_t v;
        v.rmax = r; v.busy_cyc = b; v.din = d; v.pass = p; v.dout = o;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] cur;

        add(32'hFFFF_FFFF,  0, 32'h0000_0000, 1'b1, 32'h0000_0000);
        add(32'hFFFF_FFFF,  0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        add(32'hFFFF_FFFF,  0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        add(32'd5,          4, 32'h1234_5674, 1'b1, 32'd4);
        add(32'd5,          4, 32'h0000_0006, 1'b0, 32'd0);
        add(32'd5,          4, 32'h0000_0007, 1'b0, 32'd0);
        add(32'd5,          4, 32'hFFFF_FFF5, 1'b1, 32'd5);
        add(32'd0,          1, 32'hFFFF_FFFF, 1'b1, 32'd0);
        add(32'd0,          1, 32'h1234_5678, 1'b1, 32'd0);
        add(32'd0,          1, 32'h0000_0001, 1'b1, 32'd0);
        add(32'd0,          1, 32'h8000_0000, 1'b1, 32'd0);
        add(32'h0000_1000, 14, 32'h0000_1FFF, 1'b0, 32'd0);
        add(32'h0000_1000, 14, 32'h0000_1000, 1'b1, 32'h0000_1000);
        add(32'h0000_1000, 14, 32'hABCD_0FFF, 1'b1, 32'h0000_0FFF);
        add(32'h0000_1000, 14, 32'h0000_2001, 1'b1, 32'h0000_0001);

        rst          = 1'b1;
        in_if.tdata  = '0;
        in_if.tvalid = 1'b0;
        out_if.tready = 1'b1;
        range_max    = '0;
        range_load   = 1'b0;
        reject_clear = 1'b0;
        exp_rej      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", {31'd0, out_if.tvalid}, 32'd0);
        chk("rst_tdata", out_if.tdata, 32'd0);
        chk("rst_tready", {31'd0, in_if.tready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_reject_count", reject_count, 32'd0);
        @(posedge clk);
        #1;

        cur = 32'hFFFF_FFFF;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rmax != cur) begin
                chk("tbl_reject_count", reject_count, exp_rej);
                do_load(tbl[i].rmax);
                wait_calc("tbl_load", tbl[i].busy_cyc);
                cur = tbl[i].rmax;
            end
            send(tbl[i].din, tbl[i].pass, tbl[i].dout);
            chk("tbl_latency_vld", {31'd0, out_if.tvalid}, {31'd0, tbl[i].pass});
            if (tbl[i].pass) chk("tbl_latency_data", out_if.tdata, tbl[i].dout);
        end
        chk("tbl_reject_total", reject_count, exp_rej);

        // Backpressure: output held for 5 cycles, nothing lost or duplicated.
        do_load(32'hFFFF_FFFF);
        wait_calc("full", 33);
        out_if.tready = 1'b0;
        send(32'hA5A5_0001, 1'b1, 32'hA5A5_0001);
        in_if.tdata  = 32'hA5A5_0002;
        in_if.tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_tready", {31'd0, in_if.tready}, 32'd0);
            chk("bp_hold_vld", {31'd0, out_if.tvalid}, 32'd1);
            chk("bp_hold_data", out_if.tdata, 32'hA5A5_0001);
        end
        @(posedge clk);
        #1;
        out_if.tready = 1'b1;
        send(32'hA5A5_0002, 1'b1, 32'hA5A5_0002);
        send(32'hA5A5_0003, 1'b1, 32'hA5A5_0003);
        send(32'hA5A5_0004, 1'b1, 32'hA5A5_0004);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_queue_drained", exp_q.size(), 32'd0);

        // range_load while CALC is running restarts the calculation.
        do_load(32'h0000_FFFF);
        repeat (4) @(posedge clk);
        #1;
        chk("reload_busy_mid", {31'd0, busy}, 32'd1);
        do_load(32'd3);
        wait_calc("reload", 3);
        send(32'hFFFF_FFFF, 1'b1, 32'd3);
        send(32'h1234_5676, 1'b1, 32'd2);
        send(32'h0000_0004, 1'b1, 32'd0);
        send(32'hFFFF_FFFE, 1'b1, 32'd2);

        // Reject counter saturation and clear priority.
        do_load(32'h8000_0000);
        wait_calc("r8", 33);
        force dut.reject_count_q = 32'hFFFF_FFFD;
        release dut.reject_count_q;
        exp_rej = 32'hFFFF_FFFD;
        #1;
        chk("sat_preset", reject_count, exp_rej);
        repeat (3) send(32'h8000_0001, 1'b0, 32'd0);
        chk("sat_hold", reject_count, 32'hFFFF_FFFF);
        chk("sat_model", reject_count, exp_rej);
        send(32'h0000_0005, 1'b1, 32'd5);
        reject_clear = 1'b1;
        send(32'h8000_0001, 1'b0, 32'd0);
        reject_clear = 1'b0;
        exp_rej = '0;
        chk("clear_priority", reject_count, exp_rej);

        // Reset in the middle of CALC restores pass-through.
        do_load(32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("rstcalc_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstcalc_busy", {31'd0, busy}, 32'd0);
        chk("rstcalc_tready", {31'd0, in_if.tready}, 32'd1);
        chk("rstcalc_reject_count", reject_count, 32'd0);
        send(32'hFFFF_1234, 1'b1, 32'hFFFF_1234);
        chk("rstcalc_pass_vld", {31'd0, out_if.tvalid}, 32'd1);
        chk("rstcalc_pass_data", out_if.tdata, 32'hFFFF_1234);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
